secret_code_gen: RTL and testbench

SECRET_CODE_GEN -- requirements
Module: secret_code_gen

---
 rtl/secret_code_gen.sv | 108 ++++++++++
 tb/tb_secret_code_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/secret_code_gen.sv
// Secret-code generator: draws NUM_DIGITS colour digits from an external LFSR word,
// rejecting illegal or repeated candidates, with a deterministic fill once the draw budget runs out.
module secret_code_gen #(
   parameter int NUM_DIGITS   = 4,
   parameter int NUM_COLORS   = 6,
   parameter int ALLOW_REPEAT = 1,
   parameter int MAX_DRAWS    = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [9:0]              rand_in,
   input  logic                    start,
   input  logic                    ack,
   output logic [3*NUM_DIGITS-1:0] code,
   output logic                    valid,
   output logic                    busy,
   output logic                    fallback
);

   localparam int IW = $clog2(NUM_DIGITS + 1);
   localparam int CW = $clog2(MAX_DRAWS + 1);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t          state;
   logic [IW-1:0]   slot;
   logic [CW-1:0]   draws;
   logic [7:0]      used;

   logic [2:0]      cand;
   logic            legal;
   logic            dup;
   logic            exhausted;
   logic [2:0]      fill_col;
   logic            wr;
   logic [2:0]      wr_col;
   logic            last;
   logic            unused_rand;

   assign cand        = rand_in[3:1];
   assign unused_rand = ^{rand_in[9:4], rand_in[0]};
   assign legal       = ({1'b0, cand} < 4'(NUM_COLORS));
   assign dup         = (ALLOW_REPEAT == 0) && used[cand];
   assign exhausted   = (draws == CW'(MAX_DRAWS));
   assign wr          = exhausted || (legal && !dup);
   assign wr_col      = exhausted ? fill_col : cand;
   assign last        = (slot == IW'(NUM_DIGITS - 1));

   // Descending scan so the smallest unused colour wins.
   always_comb begin
      fill_col = '0;
      if (ALLOW_REPEAT == 0) begin
         for (int c = NUM_COLORS - 1; c >= 0; c--)
            if (!used[c]) fill_col = 3'(c);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         slot     <= '0;
         draws    <= '0;
         used     <= '0;
         code     <= '0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         fallback <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= DRAW;
                  busy     <= 1'b1;
                  slot     <= '0;
                  draws    <= '0;
                  used     <= '0;
                  code     <= '0;
                  fallback <= 1'b0;
               end
            end
            DRAW: begin
               if (!exhausted) draws <= draws + 1'b1;
               if (wr) begin
                  for (int i = 0; i < NUM_DIGITS; i++)
                     if (slot == IW'(i)) code[3*i +: 3] <= wr_col;
                  used[wr_col] <= 1'b1;
                  if (exhausted) fallback <= 1'b1;
                  if (last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     valid <= 1'b1;
                  end else begin
                     slot <= slot + 1'b1;
                  end
               end
            end
            DONE: begin
               if (ack) begin
                  state <= IDLE;
                  valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_secret_code_gen.sv
// Scoreboard bench for secret_code_gen: four parameter variants share clock, reset and rand_in;
// expected code/fallback/latency is queued at start and checked when valid rises.
module tb_secret_code_gen;

   logic        clock = 1'b0;
   logic        reset;
   logic [9:0]  rand_in;
   logic [3:0]  start;
   logic [3:0]  ack;
   logic [11:0] code_v [4];
   logic [3:0]  valid;
   logic [3:0]  busy;
   logic [3:0]  fb;

   always #5 clock = ~clock;

   // 0: defaults, 1: distinct digits, 2: MAX_DRAWS=8 repeats, 3: MAX_DRAWS=8 distinct
   secret_code_gen #(.NUM_DIGITS(4), .NUM_COLORS(6), .ALLOW_REPEAT(1), .MAX_DRAWS(64)) dut0 (
      .clock(clock), .reset(reset), .rand_in(rand_in), .start(start[0]), .ack(ack[0]),
      .code(code_v[0]), .valid(valid[0]), .busy(busy[0]), .fallback(fb[0]));
   secret_code_gen #(.NUM_DIGITS(4), .NUM_COLORS(6), .ALLOW_REPEAT(0), .MAX_DRAWS(64)) dut1 (
      .clock(clock), .reset(reset), .rand_in(rand_in), .start(start[1]), .ack(ack[1]),
      .code(code_v[1]), .valid(valid[1]), .busy(busy[1]), .fallback(fb[1]));
   secret_code_gen #(.NUM_DIGITS(4), .NUM_COLORS(6), .ALLOW_REPEAT(1), .MAX_DRAWS(8)) dut2 (
      .clock(clock), .reset(reset), .rand_in(rand_in), .start(start[2]), .ack(ack[2]),
      .code(code_v[2]), .valid(valid[2]), .busy(busy[2]), .fallback(fb[2]));
   secret_code_gen #(.NUM_DIGITS(4), .NUM_COLORS(6), .ALLOW_REPEAT(0), .MAX_DRAWS(8)) dut3 (
      .clock(clock), .reset(reset), .rand_in(rand_in), .start(start[3]), .ack(ack[3]),
      .code(code_v[3]), .valid(valid[3]), .busy(busy[3]), .fallback(fb[3]));

   typedef struct {
      int          id;
      logic [11:0] code;
      logic        fb;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t       q[$];
   logic [2:0] seq[$];
   int         cyc = 0;
   int         popped = 0;
   int         checks = 0;
   int         fails = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [9:0] mk(input logic [2:0] c);
      return {6'b101101, c, 1'b1};
   endfunction

   // Monitor: pop on each rising valid and compare against the queued expectation.
   initial begin
      logic [3:0] vprev;
      exp_t e;
      vprev = '0;
      forever begin
         @(negedge clock);
         for (int i = 0; i < 4; i++) begin
            if (valid[i] && !vprev[i]) begin
               if (q.size() == 0) begin
                  chk($sformatf("unexpected_valid_dut%0d", i), 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  chk("sb_id", i, e.id);
                  chk($sformatf("sb_code_dut%0d", i), code_v[i], e.code);
                  chk($sformatf("sb_fallback_dut%0d", i), fb[i], e.fb);
                  chk($sformatf("sb_latency_dut%0d", i), cyc - e.start_cyc, e.lat);
                  chk($sformatf("sb_busy_dut%0d", i), busy[i], 1'b0);
                  popped++;
               end
            end
         end
         vprev = valid;
      end
   end

   // Issue start, feed seq (last value held), return once the monitor has seen the result.
   task automatic run(input int id, input logic [11:0] exp_code, input logic exp_fb, input int lat);
      exp_t e;
      int   p0;
      int   i;
      p0 = popped;
      @(posedge clock); #1;
      e.id = id; e.code = exp_code; e.fb = exp_fb; e.lat = lat; e.start_cyc = cyc + 1;
      q.push_back(e);
      start[id] = 1'b1;
      i = 0;
      @(posedge clock); #1;
      start[id] = 1'b0;
      chk("busy_after_start", busy[id], 1'b1);
      chk("valid_after_start", valid[id], 1'b0);
      while (popped == p0 && i < 300) begin
         rand_in = mk(seq[(i < seq.size()) ? i : seq.size() - 1]);
         @(posedge clock); #1;
         i++;
      end
      if (popped == p0) chk($sformatf("timeout_dut%0d", id), 32'd1, 32'd0);
   endtask

   task automatic do_ack(input int id, input logic [11:0] exp_code);
      ack[id] = 1'b1;
      @(posedge clock); #1;
      ack[id] = 1'b0;
      chk("valid_after_ack", valid[id], 1'b0);
      chk("code_kept_after_ack", code_v[id], exp_code);
   endtask

   initial begin
      reset = 1'b0; rand_in = '0; start = '0; ack = '0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("reset_code", code_v[i], 12'h000);
         chk("reset_flags", {valid[i], busy[i], fb[i]}, 3'b000);
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      // ack outside DONE is harmless
      ack[0] = 1'b1;
      @(posedge clock); #1;
      ack[0] = 1'b0;
      chk("ack_in_idle", {valid[0], busy[0]}, 2'b00);

      // Basic draw 2,5,0,3
      seq = '{3'd2, 3'd5, 3'd0, 3'd3};
      run(0, 12'b011_000_101_010, 1'b0, 4);
      // Hold in DONE without ack
      for (int i = 0; i < 10; i++) begin
         chk("done_hold_valid", valid[0], 1'b1);
         chk("done_hold_code", code_v[0], 12'b011_000_101_010);
         @(posedge clock); #1;
      end
      start[0] = 1'b1;
      @(posedge clock); #1;
      start[0] = 1'b0;
      chk("start_in_done_valid", {valid[0], busy[0]}, 2'b10);
      chk("start_in_done_code", code_v[0], 12'b011_000_101_010);
      // ack and start together: ack wins, FSM stays idle
      start[0] = 1'b1; ack[0] = 1'b1;
      @(posedge clock); #1;
      start[0] = 1'b0; ack[0] = 1'b0;
      chk("ack_start_flags", {valid[0], busy[0]}, 2'b00);
      chk("ack_start_code", code_v[0], 12'b011_000_101_010);
      @(posedge clock); #1;
      chk("ack_start_stays_idle", busy[0], 1'b0);

      // Rejections of 7 and 6, repeats allowed
      seq = '{3'd7, 3'd6, 3'd1, 3'd7, 3'd4, 3'd4, 3'd2};
      run(0, {3'd2, 3'd4, 3'd4, 3'd1}, 1'b0, 7);
      do_ack(0, {3'd2, 3'd4, 3'd4, 3'd1});

      // Distinct digits
      seq = '{3'd3, 3'd3, 3'd1, 3'd3, 3'd0, 3'd5};
      run(1, {3'd5, 3'd0, 3'd1, 3'd3}, 1'b0, 6);
      do_ack(1, {3'd5, 3'd0, 3'd1, 3'd3});

      // Budget exhausted, all fallback
      seq = '{3'd7};
      run(2, 12'h000, 1'b1, 12);
      do_ack(2, 12'h000);
      seq = '{3'd7};
      run(3, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b1, 12);
      do_ack(3, {3'd3, 3'd2, 3'd1, 3'd0});

      // One real draw then fallback skips the used colour
      seq = '{3'd3, 3'd7};
      run(3, {3'd2, 3'd1, 3'd0, 3'd3}, 1'b1, 11);
      do_ack(3, {3'd2, 3'd1, 3'd0, 3'd3});

      // Acceptance on the final budgeted draw, no fallback
      seq = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4};
      run(2, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, 8);
      do_ack(2, {3'd4, 3'd3, 3'd2, 3'd1});

      // Reset mid-draw after two slots
      @(posedge clock); #1;
      start[0] = 1'b1;
      @(posedge clock); #1;
      start[0] = 1'b0; rand_in = mk(3'd2);
      @(posedge clock); #1;
      rand_in = mk(3'd5);
      @(posedge clock); #1;
      rand_in = mk(3'd7);
      #3;
      chk("pre_reset_busy", busy[0], 1'b1);
      chk("pre_reset_partial", code_v[0][5:0], {3'd5, 3'd2});
      reset = 1'b0;
      #1;
      chk("async_reset_code", code_v[0], 12'h000);
      chk("async_reset_flags", {valid[0], busy[0], fb[0]}, 3'b000);
      @(posedge clock); #1;
      reset = 1'b1;
      rand_in = mk(3'd1);
      repeat (3) @(posedge clock);
      #1;
      chk("no_draw_after_reset", {valid[0], busy[0]}, 2'b00);
      seq = '{3'd1, 3'd2, 3'd3, 3'd4};
      run(0, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, 4);
      do_ack(0, {3'd4, 3'd3, 3'd2, 3'd1});

      repeat (2) @(posedge clock);
      chk("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
